// File: rtl/queue_uart_tx_if.sv
// Read-side handshake of the byte output queue: data-present flag, head word and pop strobe.
// The master side drains the queue; the slave side is the queue itself.
interface queue_uart_tx_if #(
  parameter int BITSIZE = 8
);
  logic               df;
  logic [BITSIZE-1:0] dout;
  logic               pop;

  modport master (output pop, input df, input dout);
  modport slave  (input pop, output df, output dout);
endinterface

// File: rtl/queue_uart_tx.sv
// Drains the byte output queue one entry at a time and serialises each word as an
// 8N1/8N2 UART frame, LSB first, at CLKDIV clocks per bit.
module queue_uart_tx #(
  parameter int BITSIZE  = 8,
  parameter int CLKDIV   = 868,
  parameter int STOPBITS = 1
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   en,
  queue_uart_tx_if.master        q,
  output logic                   txd,
  output logic                   busy
);

  localparam int CW = $clog2(CLKDIV);
  localparam int BW = $clog2(BITSIZE + 1);

  localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKDIV - 1);
  localparam logic [BW-1:0] BIT_ZERO  = {BW{1'b0}};
  localparam logic [BW-1:0] BIT_ONE   = BW'(1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(BITSIZE - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOPBITS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    START = 3'd2,
    DATA  = 3'd3,
    STOP  = 3'd4
  } state_t;

  state_t             state_r, state_s;
  logic [CW-1:0]      cnt_r, cnt_s;
  logic [BW-1:0]      bit_r, bit_s;
  logic [BITSIZE-1:0] shift_r, shift_s;
  logic               txd_r, txd_s;
  logic               pop_r, pop_s;
  logic               busy_r, busy_s;

  assign q.pop = pop_r;
  assign txd   = txd_r;
  assign busy  = busy_r;

  // State and output registers; reset drops the line high at once, even mid-frame.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
      bit_r   <= BIT_ZERO;
      shift_r <= {BITSIZE{1'b0}};
      txd_r   <= 1'b1;
      pop_r   <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      bit_r   <= bit_s;
      shift_r <= shift_s;
      txd_r   <= txd_s;
      pop_r   <= pop_s;
      busy_r  <= busy_s;
    end
  end

  // Next-state and next-output logic; bit_r counts data bits, then stop bits.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    bit_s   = bit_r;
    shift_s = shift_r;
    txd_s   = txd_r;
    pop_s   = 1'b0;
    busy_s  = busy_r;
    case (state_r)
      IDLE: begin
        txd_s = 1'b1;
        // DO is captured on the same edge that raises POP, before the head advances.
        if (q.df && en) begin
          shift_s = q.dout;
          pop_s   = 1'b1;
          busy_s  = 1'b1;
          state_s = LOAD;
        end else begin
          busy_s  = 1'b0;
        end
      end
      LOAD: begin
        txd_s   = 1'b0;
        cnt_s   = CNT_ZERO;
        bit_s   = BIT_ZERO;
        state_s = START;
      end
      START: begin
        if (cnt_r == CNT_LAST) begin
          cnt_s   = CNT_ZERO;
          bit_s   = BIT_ZERO;
          txd_s   = shift_r[0];
          state_s = DATA;
        end else begin
          cnt_s   = cnt_r + CNT_ONE;
        end
      end
      DATA: begin
        if (cnt_r == CNT_LAST) begin
          cnt_s = CNT_ZERO;
          if (bit_r == BIT_LAST) begin
            bit_s   = BIT_ZERO;
            txd_s   = 1'b1;
            state_s = STOP;
          end else begin
            shift_s = shift_r >> 1'b1;
            txd_s   = shift_s[0];
            bit_s   = bit_r + BIT_ONE;
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      STOP: begin
        if (cnt_r == CNT_LAST) begin
          cnt_s = CNT_ZERO;
          if (bit_r == STOP_LAST) begin
            bit_s   = BIT_ZERO;
            busy_s  = 1'b0;
            state_s = IDLE;
          end else begin
            bit_s   = bit_r + BIT_ONE;
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_s = IDLE;
        txd_s   = 1'b1;
        pop_s   = 1'b0;
        busy_s  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_queue_uart_tx.sv
// Bench for queue_uart_tx: two instances (8N1 and 8N2, 4 clocks per bit) fed from bench-side
// queues, compared every cycle against a frame-timeline model plus directed literal checks.
module tb_queue_uart_tx;

  logic clk = 1'b0;
  logic rstn;
  logic en;
  logic txd0, busy0, txd1, busy1;

  queue_uart_tx_if #(.BITSIZE(8)) q0 ();
  queue_uart_tx_if #(.BITSIZE(8)) q1 ();

  queue_uart_tx #(.BITSIZE(8), .CLKDIV(4), .STOPBITS(1)) dut0 (
    .clk(clk), .rstn(rstn), .en(en), .q(q0), .txd(txd0), .busy(busy0));
  queue_uart_tx #(.BITSIZE(8), .CLKDIV(4), .STOPBITS(2)) dut1 (
    .clk(clk), .rstn(rstn), .en(en), .q(q1), .txd(txd1), .busy(busy1));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [7:0] bq0[$];
  logic [7:0] bq1[$];
  int pops0[$];
  int pops1[$];
  logic log0[$];
  int busy0_n, busy1_n;

  // Model: a frame is t = 0 (pop cycle) then (1+8+stop)*4 line cycles, then one idle edge.
  logic       act_m[2] = '{1'b0, 1'b0};
  int         t_m[2]   = '{0, 0};
  logic [7:0] lat_m[2] = '{8'h00, 8'h00};

  function automatic int flen(input int i);
    return (1 + 8 + ((i == 0) ? 1 : 2)) * 4;
  endfunction

  function automatic logic [2:0] model_out(input int i);
    int idx;
    logic lvl;
    if (!act_m[i]) return 3'b001;
    if (t_m[i] == 0) return 3'b111;
    idx = (t_m[i] - 1) / 4;
    if (idx == 0) lvl = 1'b0;
    else if (idx <= 8) lvl = lat_m[i][idx-1];
    else lvl = 1'b1;
    return {1'b0, 1'b1, lvl};
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 2; i++) begin
        act_m[i] <= 1'b0;
        t_m[i]   <= 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (act_m[i]) begin
          t_m[i] <= t_m[i] + 1;
          if (t_m[i] + 1 == flen(i) + 1) act_m[i] <= 1'b0;
        end else if (((i == 0) ? q0.df : q1.df) && en) begin
          act_m[i] <= 1'b1;
          t_m[i]   <= 0;
          lat_m[i] <= (i == 0) ? q0.dout : q1.dout;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", nm, $time, act, req);
    end
  endtask

  task automatic drive();
    q0.df   = (bq0.size() > 0);
    q0.dout = (bq0.size() > 0) ? bq0[0] : 8'h00;
    q1.df   = (bq1.size() > 0);
    q1.dout = (bq1.size() > 0) ? bq1[0] : 8'h00;
  endtask

  task automatic push(input logic [7:0] b0, input logic [7:0] b1);
    bq0.push_back(b0);
    bq1.push_back(b1);
    drive();
  endtask

  // One cycle: compare against the model on the falling edge, then serve the queues.
  task automatic tick();
    logic [2:0] o0, o1;
    @(negedge clk);
    cyc++;
    o0 = model_out(0);
    o1 = model_out(1);
    chk("pop0",  32'(q0.pop), 32'(o0[2]));
    chk("busy0", 32'(busy0),  32'(o0[1]));
    chk("txd0",  32'(txd0),   32'(o0[0]));
    chk("pop1",  32'(q1.pop), 32'(o1[2]));
    chk("busy1", 32'(busy1),  32'(o1[1]));
    chk("txd1",  32'(txd1),   32'(o1[0]));
    if (q0.pop) begin
      pops0.push_back(cyc);
      if (bq0.size() > 0) void'(bq0.pop_front());
    end
    if (q1.pop) begin
      pops1.push_back(cyc);
      if (bq1.size() > 0) void'(bq1.pop_front());
    end
    busy0_n += int'(busy0);
    busy1_n += int'(busy1);
    log0.push_back(txd0);
    drive();
  endtask

  task automatic clear_logs();
    pops0.delete();
    pops1.delete();
    log0.delete();
    busy0_n = 0;
    busy1_n = 0;
  endtask

  initial begin
    logic [9:0] pat;
    int base, pi, n;
    pat  = 10'b1101001010;
    rstn = 1'b0;
    en   = 1'b0;
    drive();

    // Reset, then idle with an empty queue.
    repeat (5) tick();
    #2 rstn = 1'b1;
    en = 1'b1;
    clear_logs();
    repeat (100) tick();
    chk("idle_no_pop0", 32'(pops0.size()), 32'd0);
    chk("idle_no_pop1", 32'(pops1.size()), 32'd0);

    // Single byte: A5 on 8N1, 3C on 8N2.
    clear_logs();
    base = cyc;
    push(8'hA5, 8'h3C);
    repeat (70) tick();
    chk("single_pops0", 32'(pops0.size()), 32'd1);
    chk("single_pops1", 32'(pops1.size()), 32'd1);
    chk("single_busy0", 32'(busy0_n), 32'd41);
    chk("single_busy1", 32'(busy1_n), 32'd45);
    if (pops0.size() == 1) begin
      pi = pops0[0] - base - 1;
      chk("a5_load_high", 32'(log0[pi]), 32'd1);
      for (int k = 0; k < 10; k++)
        for (int c = 0; c < 4; c++)
          chk("a5_level", 32'(log0[pi + 1 + 4*k + c]), 32'(pat[k]));
      chk("a5_after_stop", 32'(log0[pi + 41]), 32'd1);
    end

    // Back-to-back frames.
    clear_logs();
    push(8'h00, 8'h00);
    push(8'hFF, 8'hFF);
    repeat (110) tick();
    chk("b2b_pops0", 32'(pops0.size()), 32'd2);
    chk("b2b_pops1", 32'(pops1.size()), 32'd2);
    if (pops0.size() == 2) chk("b2b_gap0", 32'(pops0[1] - pops0[0]), 32'd42);
    if (pops1.size() == 2) chk("b2b_gap1", 32'(pops1[1] - pops1[0]), 32'd46);

    // EN gating.
    clear_logs();
    en = 1'b0;
    push(8'h11, 8'h11);
    push(8'h22, 8'h22);
    repeat (20) tick();
    chk("en_low_no_pop", 32'(pops0.size()), 32'd0);
    chk("en_low_txd", 32'(txd0), 32'd1);
    en = 1'b1;
    tick();
    chk("en_rise_pop", 32'(pops0.size()), 32'd1);
    repeat (10) tick();
    en = 1'b0;
    repeat (80) tick();
    chk("en_drop_pops0", 32'(pops0.size()), 32'd1);
    chk("en_drop_pops1", 32'(pops1.size()), 32'd1);
    chk("en_drop_left", 32'(bq0.size()), 32'd1);

    // Reset in data bit 3, then a full frame of the next entry.
    clear_logs();
    push(8'h5A, 8'h5A);
    push(8'hC3, 8'hC3);
    en = 1'b1;
    n = 0;
    while (pops0.size() == 0 && n < 20) begin
      tick();
      n++;
    end
    chk("rst_wait_pop", 32'(pops0.size()), 32'd1);
    repeat (18) tick();
    chk("rst_pre_busy", 32'(busy0), 32'd1);
    #2 rstn = 1'b0;
    #1;
    chk("rst_async_txd0",  32'(txd0),  32'd1);
    chk("rst_async_busy0", 32'(busy0), 32'd0);
    chk("rst_async_txd1",  32'(txd1),  32'd1);
    chk("rst_async_busy1", 32'(busy1), 32'd0);
    repeat (3) tick();
    #2 rstn = 1'b1;
    clear_logs();
    repeat (30) tick();
    chk("rst_repop0", 32'(pops0.size()), 32'd1);
    chk("rst_left0",  32'(bq0.size()), 32'd1);
    repeat (60) tick();

    // Random traffic with EN toggling.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) push(8'($urandom), 8'($urandom));
      if ($urandom_range(0, 63) == 0) en = ~en;
      tick();
    end
    en = 1'b1;
    repeat (200) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
